// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU memory subsystem.
package cpu_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  // Who performed a read in the previous cycle (owns the RAM read data now).
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    LDR_RD = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter sharing a single-port synchronous RAM between the CPU control path
// and the boot loader / debug port. Grants are decided combinationally each
// cycle; read data (1-cycle latency) is steered to the requester that issued it.
module mem_arbiter #(
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot,
  input  logic              cpu_en,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  import cpu_pkg::*;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  owner_t            owner_q, owner_d;
  logic [3:0]        wait_q, wait_d;
  logic [DATA_W-1:0] cpu_hold_q;
  logic              cpu_gnt_s, ldr_gnt_s;
  logic              contend_s;

  assign contend_s = cpu_en & ldr_req;

  // Grant decision: reset, then boot ownership, then contention fairness.
  always_comb begin
    cpu_gnt_s = 1'b0;
    ldr_gnt_s = 1'b0;
    if (rst) begin
      cpu_gnt_s = 1'b0;
      ldr_gnt_s = 1'b0;
    end else if (boot) begin
      cpu_gnt_s = 1'b0;
      ldr_gnt_s = ldr_req;
    end else if (contend_s) begin
      ldr_gnt_s = (wait_q == MAX_WAIT_C);
      cpu_gnt_s = (wait_q != MAX_WAIT_C);
    end else begin
      cpu_gnt_s = cpu_en;
      ldr_gnt_s = ldr_req;
    end
  end

  // RAM port mux from the granted side; quiet bus when nobody is granted.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt_s) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ldr_gnt_s) begin
      mem_we    = ldr_we;
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
    end else begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  assign mem_en    = cpu_gnt_s | ldr_gnt_s;
  assign ldr_gnt   = ldr_gnt_s;
  assign cpu_stall = ~rst & (boot | (cpu_en & ~cpu_gnt_s));

  // Loader starvation counter and next read owner.
  always_comb begin
    wait_d  = wait_q;
    owner_d = IDLE;
    if (!ldr_req || ldr_gnt_s) begin
      wait_d = 4'd0;
    end else if (contend_s && (wait_q < MAX_WAIT_C)) begin
      wait_d = wait_q + 4'd1;
    end else begin
      wait_d = wait_q;
    end
    if (cpu_gnt_s && !cpu_we) begin
      owner_d = CPU_RD;
    end else if (ldr_gnt_s && !ldr_we) begin
      owner_d = LDR_RD;
    end else begin
      owner_d = IDLE;
    end
  end

  // Owner FSM, wait counter and CPU read-data hold register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= IDLE;
      wait_q     <= 4'd0;
      cpu_hold_q <= '0;
    end else begin
      owner_q <= owner_d;
      wait_q  <= wait_d;
      if (owner_q == CPU_RD) begin
        cpu_hold_q <= mem_rdata;
      end
    end
  end

  // CPU sees live RAM data only on its own read cycle, else its last read.
  assign cpu_rdata  = (owner_q == CPU_RD) ? mem_rdata : cpu_hold_q;
  assign ldr_rvalid = (owner_q == LDR_RD);
  assign ldr_rdata  = (owner_q == LDR_RD) ? mem_rdata : '0;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port synchronous program/data RAM (64 x 8) between two requesters:
  - the CPU control path (fetch/operand/store accesses issued by the instruction sequencer);
  - the boot loader / debug port.
- Same-cycle grant decision.
- Stalls the CPU through its clock-enable when the CPU loses arbitration.
- Steers the 1-cycle-latency read data back to whichever requester issued the read.

Parameters:
- ADDR_W, 6, memory address width.
- DATA_W, 8, memory data width.
- MAX_WAIT, 4, contended cycles the loader may lose before it wins the next contention (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- boot  in  1  1 = loader owns memory exclusively; CPU held.
- cpu_en  in  1  CPU access request, held while stalled.
- cpu_we  in  1  CPU write.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data.
- cpu_stall  out  1  CPU must not advance; system ce = ce_in & ~cpu_stall.
- ldr_req  in  1  loader request; addr/we/wdata stable until granted.
- ldr_we  in  1  loader write.
- ldr_addr  in  ADDR_W  loader address.
- ldr_wdata  in  DATA_W  loader write data.
- ldr_gnt  out  1  loader beat accepted this cycle.
- ldr_rvalid  out  1  loader read data valid.
- ldr_rdata  out  DATA_W  loader read data.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after a read.

Behaviour:
- Grant logic is combinational each cycle, decided in this priority order:
  - rst=1: no grants.
  - boot=1: loader only.
  - Contention (cpu_en & ldr_req): loader wins iff wait_cnt==MAX_WAIT; otherwise CPU wins.
  - Otherwise the single requester is granted.
- Memory port:
  - mem_en = cpu_gnt | ldr_gnt.
  - mem_we, mem_addr, mem_wdata are muxed from the granted side.
  - With no grant, mem_we=0 and addr/wdata=0.
- cpu_stall = cpu_en & ~cpu_gnt, plus forced 1 whenever boot=1.
- Writes complete in the grant cycle; there is no write response.
- wait_cnt (4 bit):
  - increments on each contended cycle the loader loses;
  - clears on any loader grant, or when ldr_req=0;
  - saturates at MAX_WAIT.
- Owner FSM, registered; records who performed a read in the previous cycle.
  - States: IDLE, CPU_RD, LDR_RD.
  - Next state: CPU_RD if the CPU read is granted; LDR_RD if the loader read is granted; otherwise IDLE (this includes writes).
- Read data routing:
  - In CPU_RD: cpu_rdata = mem_rdata, and cpu_hold <= mem_rdata. In all other states cpu_rdata = cpu_hold, so a loader read never disturbs CPU data.
  - In LDR_RD: ldr_rvalid = 1 and ldr_rdata = mem_rdata. Otherwise ldr_rvalid = 0 and ldr_rdata = 0.
- Latency: a read granted in cycle N has its data on the requester's port in cycle N+1.
- Reset values:
  - State IDLE, wait_cnt 0, cpu_hold 0.
  - All grants, mem_en, mem_we, ldr_rvalid: 0. cpu_rdata: 0. cpu_stall: 0.
- Reset mid-operation: an in-flight read is discarded; ldr_rvalid is not asserted after rst deasserts.
- boot edges:
  - boot rising while a CPU read is in flight: the CPU_RD data is still captured into cpu_hold.
  - boot falling: the CPU resumes on the next cycle with normal priority; wait_cnt is unaffected.
- Simultaneous requests with identical addresses receive no special handling; strict serialisation.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W/DATA_W constants.
  - owner_t enum {IDLE, CPU_RD, LDR_RD}.
- Single module.
- The wait counter and hold register are inline; no sub-module is warranted.

Test Plan:
- CPU read alone, RAM[0x05]=0xA3, cpu_en=1 addr 0x05 -> mem_en=1, cpu_stall=0 same cycle; cpu_rdata=0xA3 next cycle; ldr_rvalid stays 0.
- Contention, cpu_en read 0x01 and ldr_req write 0x02<=0x55 in the same cycle -> CPU granted, ldr_gnt=0, wait_cnt=1. Next cycle with cpu_en=0 -> ldr_gnt=1, mem_we=1, RAM[0x02]=0x55.
- Starvation, cpu_en held high continuously with ldr_req held (MAX_WAIT=4) -> CPU wins 4 cycles; 5th cycle ldr_gnt=1 and cpu_stall=1; wait_cnt back to 0.
- boot=1, loader writes 0x00..0x3F with data=addr^0xFF while cpu_en=1 -> cpu_stall=1 throughout. Then boot=0, CPU read 0x10 -> cpu_rdata=0xEF.
- Back-to-back reads, CPU reads 0x03 (=0x11) then loader reads 0x04 (=0x22) -> cpu_rdata=0x11 and stays 0x11; ldr_rvalid=1 with ldr_rdata=0x22 one cycle later.
- rst asserted the cycle after a loader read grant -> ldr_gnt and ldr_rvalid are 0 immediately; state IDLE, wait_cnt=0; no rvalid after release.
